// File: rtl/sc_tx_scheduler.sv
// Round-robin scheduler sharing one serializer data word between several requesters.
// A grant presents the requester's word; a frame is only expected when the word changes.
package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module sc_tx_scheduler
  import ckrs_pkg::*;
#(
  parameter int g_Requesters    = 4,
  parameter int g_TimeoutCycles = 1024
) (
  input  ckrs_t                         ClkRs_ix,
  input  logic [g_Requesters-1:0]       Req_ib,
  input  logic [g_Requesters-1:0][31:0] Data_ib32,
  input  logic                          TxBusy_i,
  input  logic                          LinkUp_i,
  output logic [31:0]                   data_ob32,
  output logic [g_Requesters-1:0]       Grant_ob,
  output logic [g_Requesters-1:0]       Ack_ob,
  output logic [g_Requesters-1:0]       Err_ob,
  output logic                          Idle_o,
  output logic [1:0]                    State_ob2
);

  localparam int IW = (g_Requesters > 1) ? $clog2(g_Requesters) : 1;
  localparam int CW = $clog2(g_TimeoutCycles);
  localparam logic [CW-1:0] CNT_LAST = CW'(g_TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           last, last_nxt;
  logic [31:0]             data_nxt;
  logic [g_Requesters-1:0] grant_nxt, ack_nxt, err_nxt;
  logic                    idle_nxt;

  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           cand;
  logic [g_Requesters-1:0] pick_oh;
  logic [31:0]             pick_word;

  assign State_ob2 = state;

  // Search begins one past the last owner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= g_Requesters; k++) begin
      cand = IW'((int'(last) + k) % g_Requesters);
      if (!pick_valid && Req_ib[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_word         = Data_ib32[pick_idx];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    data_nxt  = data_ob32;
    grant_nxt = Grant_ob;
    ack_nxt   = '0;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (LinkUp_i && !TxBusy_i && pick_valid) begin
          grant_nxt = pick_oh;
          last_nxt  = pick_idx;
          // An unchanged word starts no frame, so it is acknowledged at once.
          if (pick_word != data_ob32) begin
            data_nxt  = pick_word;
            cnt_nxt   = '0;
            state_nxt = WAIT_BUSY;
          end else begin
            ack_nxt   = pick_oh;
            state_nxt = HOLD;
          end
        end
      end
      WAIT_BUSY: begin
        if (TxBusy_i) begin
          ack_nxt   = Grant_ob;
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = Grant_ob;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!TxBusy_i || !LinkUp_i) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
    idle_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= IW'(g_Requesters - 1);
      data_ob32 <= '0;
      Grant_ob  <= '0;
      Ack_ob    <= '0;
      Err_ob    <= '0;
      Idle_o    <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      data_ob32 <= data_nxt;
      Grant_ob  <= grant_nxt;
      Ack_ob    <= ack_nxt;
      Err_ob    <= err_nxt;
      Idle_o    <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_sc_tx_scheduler.sv
// Scoreboard bench for sc_tx_scheduler: directed timing cases, then random request
// batches predicted by a transaction-level round-robin model.
module tb_sc_tx_scheduler;
  import ckrs_pkg::*;

  localparam int N = 4;
  localparam int T = 16;
  localparam int NO_BUSY = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  ckrs_t clk_rs;
  assign clk_rs = {clk, rst};
  always #5 clk = ~clk;

  logic [N-1:0]       req;
  logic [N-1:0][31:0] data;
  logic               busy;
  logic               link;
  logic [31:0]        data_o;
  logic [N-1:0]       grant, ack, err;
  logic               idle;
  logic [1:0]         state_dbg;

  sc_tx_scheduler #(.g_Requesters(N), .g_TimeoutCycles(T)) dut (
    .ClkRs_ix (clk_rs),
    .Req_ib   (req),
    .Data_ib32(data),
    .TxBusy_i (busy),
    .LinkUp_i (link),
    .data_ob32(data_o),
    .Grant_ob (grant),
    .Ack_ob   (ack),
    .Err_ob   (err),
    .Idle_o   (idle),
    .State_ob2(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [35:0] exp_q[$];   // {is_err, owner index, word}
  int          delay_q[$]; // serializer: cycles until busy rises (NO_BUSY = never)
  int          dur_q[$];   // serializer: busy length
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_word = '0;
  int          m_ptr  = N - 1;
  logic [31:0] bat_data[N];
  int          bat_delay[N];
  int          bat_dur[N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input bit is_err, input int idx, input logic [31:0] w);
    exp_q.push_back({is_err, 3'(idx), w});
  endtask

  task automatic push_frame(input int d, input int du);
    delay_q.push_back(d);
    dur_q.push_back(du);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int maxc, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (((ack | err) == '0) && k < maxc);
    chk("response_seen", |(ack | err), 1);
  endtask

  task automatic wait_idle();
    int k;
    link = 1'b1;
    k = 0;
    while (!(idle && !busy) && k < 200) begin
      tick();
      k++;
    end
    chk("idle_reached", idle && !busy, 1);
  endtask

  // Model: requests held until served are granted in round-robin order from the pointer.
  task automatic run_batch(input logic [N-1:0] mask, input bit rnd);
    int          order[$];
    int          p;
    int          budget;
    logic [N-1:0] drop;
    logic [31:0] w;
    for (int k = 1; k <= N; k++) begin
      p = (m_ptr + k) % N;
      if (mask[p]) order.push_back(p);
    end
    foreach (order[j]) begin
      int i;
      i = order[j];
      if (rnd) begin
        bat_data[i] = ($urandom_range(0, 3) == 0) ? m_word : $urandom;
        case ($urandom_range(0, 9))
          0, 1:    bat_delay[i] = NO_BUSY;
          2:       bat_delay[i] = T - 1;
          3:       bat_delay[i] = T - 2;
          default: bat_delay[i] = $urandom_range(1, 8);
        endcase
        bat_dur[i] = $urandom_range(1, 4);
      end
      w = bat_data[i];
      if (w == m_word) begin
        push_exp(1'b0, i, w);
      end else begin
        push_exp(bat_delay[i] >= T, i, w);
        push_frame(bat_delay[i], bat_dur[i]);
      end
      m_word = w;
      m_ptr  = i;
    end
    for (int i = 0; i < N; i++) if (mask[i]) data[i] = bat_data[i];
    req    = mask;
    budget = 0;
    while (req != '0 && budget < 3000) begin
      @(negedge clk);
      drop = ack | err;
      for (int i = 0; i < N; i++) if (grant[i]) data[i] = $urandom;
      tick();
      req = req & ~drop;
      if (rnd) link = ($urandom_range(0, 3) != 0);
      budget++;
    end
    chk("batch_done", req, 0);
    wait_idle();
  endtask

  // ---------------- serializer model ----------------
  initial begin
    logic [31:0] prev_d;
    int          d, du;
    bit          hit;
    busy   = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_d = data_o;
      end else if (data_o != prev_d) begin
        prev_d = data_o;
        if (delay_q.size() == 0) begin
          chk("unexpected_frame", data_o, prev_d ^ 32'hffff_ffff);
        end else begin
          d  = delay_q.pop_front();
          du = dur_q.pop_front();
          if (d < NO_BUSY) begin
            hit = 1'b0;
            repeat (d) begin tick(); hit |= rst; end
            busy = 1'b1;
            repeat (du) begin tick(); hit |= rst; end
            busy = 1'b0;
            if (hit) prev_d = '0;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if ((ack | err) != '0) begin
        chk("ack_err_exclusive", (ack != '0) && (err != '0), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_response", {ack, err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind", err != '0, e[35]);
          chk("resp_owner", ack | err, 4'b0001 << e[34:32]);
          chk("resp_word", data_o, e[31:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    req  = '0;
    data = '0;
    link = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    @(negedge clk) rst = 1'b0;

    // Single requester, busy rises 3 cycles after the word changes.
    push_exp(1'b0, 0, 32'haabbccdd);
    push_frame(3, 2);
    tick();
    data[0] = 32'haabbccdd;
    req     = 4'b0001;
    tick();
    chk("a_grant", grant, 4'b0001);
    chk("a_data", data_o, 32'haabbccdd);
    wait_out(30, k);
    chk("a_ack_latency", k, 4);
    tick();
    req = '0;
    chk("a_ack_one_cycle", ack, 0);
    wait_idle();

    // Same word presented again: immediate ack, no frame.
    push_exp(1'b0, 1, 32'h1);
    push_frame(2, 1);
    data[1] = 32'h1;
    req     = 4'b0010;
    wait_out(30, k);
    tick();
    req = '0;
    wait_idle();
    push_exp(1'b0, 2, 32'h1);
    data[2] = 32'h1;
    req     = 4'b0100;
    tick();
    chk("b_ack_now", ack, 4'b0100);
    chk("b_data_same", data_o, 32'h1);
    tick();
    req = '0;
    chk("b_hold_one_cycle", idle, 1);
    chk("b_grant_cleared", grant, 0);
    wait_idle();

    // Busy never rises: error after T cycles, word kept.
    push_exp(1'b1, 0, 32'hcafef00d);
    push_frame(NO_BUSY, 1);
    data[0] = 32'hcafef00d;
    req     = 4'b0001;
    tick();
    chk("c_data", data_o, 32'hcafef00d);
    wait_out(40, k);
    chk("c_timeout_latency", k, T);
    chk("c_no_ack", ack, 0);
    tick();
    req = '0;
    chk("c_data_kept", data_o, 32'hcafef00d);
    chk("c_idle_after_hold", idle, 1);
    wait_idle();

    // Link down blocks grants; raising it grants next cycle.
    link    = 1'b0;
    data[1] = 32'h12345678;
    req     = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d_no_grant", {grant, idle}, {4'b0000, 1'b1});
    end
    push_exp(1'b0, 1, 32'h12345678);
    push_frame(2, 2);
    link = 1'b1;
    tick();
    chk("d_grant_on_link", grant, 4'b0010);
    wait_out(30, k);
    tick();
    req = '0;
    wait_idle();

    // Reset while waiting for busy to fall.
    push_exp(1'b0, 2, 32'h5a5a5a5a);
    push_frame(1, 30);
    data[2] = 32'h5a5a5a5a;
    req     = 4'b0100;
    wait_out(30, k);
    tick();
    req = '0;
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    chk("e_rst_data", data_o, 0);
    chk("e_rst_grant", grant, 0);
    chk("e_rst_ackerr", {ack, err}, 0);
    chk("e_rst_idle", idle, 1);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    m_word = '0;
    m_ptr  = N - 1;
    bat_data[0] = 32'h11112222; bat_delay[0] = 2; bat_dur[0] = 1;
    bat_data[3] = 32'h33334444; bat_delay[3] = 3; bat_dur[3] = 2;
    run_batch(4'b1001, 1'b0);

    // All four requesting: order 0,1,2,3.
    for (int i = 0; i < N; i++) begin
      bat_data[i]  = 32'h1000 + i;
      bat_delay[i] = 2 + i;
      bat_dur[i]   = 2;
    end
    run_batch(4'b1111, 1'b0);

    // Random batches with link toggling.
    for (int b = 0; b < 40; b++) run_batch(4'($urandom_range(1, 15)), 1'b1);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    chk("exp_q_drained", exp_q.size(), 0);
    chk("frames_drained", delay_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_tx_scheduler.md
SC_TX_SCHEDULER -- requirements
Module: sc_tx_scheduler

Interface
REQ-001 Parameter g_Requesters, default 4: number of requesters sharing one serial-register transmit channel, range 2..8.
REQ-002 Parameter g_TimeoutCycles, default 1024: maximum cycles to wait for TxBusy_i to rise after a word is presented, minimum 2.
REQ-003 ClkRs_ix  input  ckrs_t: ClkRs_ix.clk is the single clock; ClkRs_ix.reset is a synchronous, active-high reset.
REQ-004 Req_ib  input  g_Requesters: per-requester transmit request, held until the matching Ack_ob or Err_ob bit.
REQ-005 Data_ib32  input  g_Requesters x 32: per-requester word to send.
REQ-006 TxBusy_i  input  1: serializer busy flag. The serializer starts a frame whenever data_ob32 changes.
REQ-007 LinkUp_i  input  1: serial link RX locked.
REQ-008 data_ob32  output  32: word driven to the serializer data input.
REQ-009 Grant_ob  output  g_Requesters: one-hot owner of the current transaction; all zeros when no transaction is active.
REQ-010 Ack_ob  output  g_Requesters: one-cycle pulse, word accepted.
REQ-011 Err_ob  output  g_Requesters: one-cycle pulse, timeout.
REQ-012 Idle_o  output  1: high in IDLE state.

Function
REQ-013 FSM states are IDLE, WAIT_BUSY, WAIT_DONE and HOLD. All outputs are registered.
REQ-014 IDLE grants a requester only when LinkUp_i=1, TxBusy_i=0 and at least one Req_ib bit is set; otherwise the FSM stays in IDLE.
REQ-015 Arbitration is round-robin. Search starts at the index after the last granted requester and wraps from g_Requesters-1 to 0.
REQ-016 A grant at cycle edge n sets Grant_ob and latches Data_ib32[i] into the working word at n+1.
REQ-017 If the latched word differs from the current data_ob32:
- data_ob32 takes the latched word at n+1;
- the timeout counter clears;
- the FSM enters WAIT_BUSY.
REQ-018 If the latched word equals the current data_ob32, no frame is generated: Ack_ob[i]=1 at n+1 and the FSM enters HOLD.
REQ-019 WAIT_BUSY with TxBusy_i=1 pulses Ack_ob[i] for one cycle and enters WAIT_DONE.
REQ-020 WAIT_BUSY: the counter increments each cycle. When the counter reaches g_TimeoutCycles-1 with TxBusy_i still 0:
- Err_ob[i] pulses for one cycle;
- the FSM enters HOLD;
- data_ob32 keeps the new word.
REQ-021 WAIT_DONE returns to IDLE when TxBusy_i=0 or LinkUp_i=0.
REQ-022 HOLD lasts exactly one cycle (the Ack or Err cycle) and then returns to IDLE. Grant_ob clears on leaving HOLD.
REQ-023 A requester deasserts Req_ib in the cycle after its Ack or Err. The HOLD state guarantees it is not re-granted from a stale request.
REQ-024 A Req_ib drop after grant does not abort the transaction; the Ack or Err is still issued.
REQ-025 LinkUp_i=0 during WAIT_BUSY does not abort; timeout still applies.
REQ-026 Data_ib32 changes after grant are ignored until the next grant.
REQ-027 Ack_ob and Err_ob are never high in the same cycle, and at most one bit of each is high.
REQ-028 The round-robin pointer updates on every grant, including same-word grants.

Reset
REQ-029 While ClkRs_ix.reset=1, at the next clock edge:
- the FSM enters IDLE;
- data_ob32=0, Grant_ob=0, Ack_ob=0, Err_ob=0, Idle_o=1;
- the counter clears;
- the round-robin pointer is set so requester 0 has highest priority.
REQ-030 A reset mid-transaction discards the transaction with no Ack or Err. The first grant after reset obeys REQ-014.

Verification
REQ-031 Req_ib=4'b0001, Data_ib32[0]=32'haabbccdd, TxBusy rises 3 cycles after the change -> data_ob32=32'haabbccdd one cycle after the grant; Ack_ob=4'b0001 for exactly one cycle.
REQ-032 Req_ib=4'b1111 held continuously, with each requester dropping Req one cycle after its Ack -> grant order 0,1,2,3 with no requester granted twice.
REQ-033 Data_ib32[2] equals the current data_ob32 (32'h1) -> Ack_ob=4'b0100 one cycle after the grant, no change on data_ob32, zero cycles spent in WAIT_BUSY.
REQ-034 TxBusy_i held 0 after the word is presented, g_TimeoutCycles=16 -> Err_ob pulses 16 cycles after data_ob32 changes; no Ack_ob.
REQ-035 LinkUp_i=0 with Req_ib=4'b0010 -> no grant and Idle_o stays 1. Raising LinkUp_i -> grant in the next cycle.
REQ-036 Reset asserted in WAIT_DONE -> all outputs at reset values at the next edge, no Ack or Err pulse. After release, Req_ib=4'b1001 -> requester 0 granted first.
